// File: rtl/icache_ctrl_pkg.sv
// Shared constants, state encodings and byte-lane helper for the instruction cache.
package icache_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned IDX_W_DEF  = 8;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned BYTE_W     = 8;

  // Reset is asserted when rst equals this level.
  localparam logic RST_ENABLE = 1'b0;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  // Fill FSM encodings.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  // Replace byte lane 'lane' of 'word' with 'b' (little-endian lane order).
  function automatic logic [INST_W-1:0] put_byte(input logic [INST_W-1:0] word,
                                                 input logic [1:0]        lane,
                                                 input logic [BYTE_W-1:0] b);
    logic [INST_W-1:0] w;
    w = word;
    w[{lane, 3'b000} +: BYTE_W] = b;
    return w;
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  import icache_ctrl_pkg::*;

  logic [ADDR_W-1:0] inst_addr_i;
  logic              inst_enable_o;
  logic [INST_W-1:0] inst_data_o;
  logic              clear_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic [BYTE_W-1:0] mem_din_i;

  // Cache side.
  modport slave (
    input  inst_addr_i, clear_i, mem_gnt_i, mem_din_i,
    output inst_enable_o, inst_data_o, mem_req_o, mem_addr_o
  );

  // Environment side (fetch stage + memory arbiter).
  modport master (
    output inst_addr_i, clear_i, mem_gnt_i, mem_din_i,
    input  inst_enable_o, inst_data_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/icache_ctrl_ram.sv
// Valid/tag/data arrays: combinational read, synchronous write, synchronous clear-all.
module icache_ctrl_ram
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned TAG_W = 22
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [INST_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rvalid_c,
  output logic [TAG_W-1:0]  rtag_c,
  output logic [INST_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 32'(1) << IDX_W;

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [INST_W-1:0] data_q [DEPTH];

  // Valid bits: clear-all has priority over a line install.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[widx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign rvalid_c = valid_q[ridx];
  assign rtag_c   = tag_q[ridx];
  assign rdata_c  = data_q[ridx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache: combinational hit path, four-byte little-endian line fill.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  icache_ctrl_if.slave bus
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam int unsigned WA_W  = ADDR_W - 2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WA_W-1:0]   miss_q, miss_d;
  logic [INST_W-1:0] word_q, word_d;

  logic              in_rst_c;
  logic              ram_clr_c;
  logic              ram_we_c;
  logic              rvalid_c;
  logic [TAG_W-1:0]  rtag_c;
  logic [INST_W-1:0] rdata_c;
  logic              hit_c;
  logic [IDX_W-1:0]  fetch_idx_c;
  logic [TAG_W-1:0]  fetch_tag_c;
  logic              unused_addr_lsbs;

  // Byte offset of the fetch address is irrelevant to a word-per-line cache.
  assign unused_addr_lsbs = ^bus.inst_addr_i[1:0];

  assign in_rst_c    = (rst == RST_ENABLE);
  assign fetch_idx_c = bus.inst_addr_i[IDX_W+1:2];
  assign fetch_tag_c = bus.inst_addr_i[ADDR_W-1:IDX_W+2];

  // Reset and flush both wipe every line; a flush in WRITE suppresses the install.
  assign ram_clr_c = in_rst_c || bus.clear_i;
  assign ram_we_c  = (state_q == S_WRITE) && !ram_clr_c;

  icache_ctrl_ram #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_ram (
    .clk      (clk),
    .clr      (ram_clr_c),
    .we       (ram_we_c),
    .widx     (miss_q[IDX_W-1:0]),
    .wtag     (miss_q[WA_W-1:IDX_W]),
    .wdata    (word_q),
    .ridx     (fetch_idx_c),
    .rvalid_c (rvalid_c),
    .rtag_c   (rtag_c),
    .rdata_c  (rdata_c)
  );

  // Hit path is live in every FSM state and forced off while in reset.
  assign hit_c             = rvalid_c && (rtag_c == fetch_tag_c) && !in_rst_c;
  assign bus.inst_enable_o = hit_c;
  assign bus.inst_data_o   = hit_c ? rdata_c : ZERO_WORD;

  // Memory port decoded only from registered state; word-aligned base never carries.
  assign bus.mem_req_o  = (state_q == S_REQ);
  assign bus.mem_addr_o = (state_q == S_REQ) ? {miss_q, cnt_q} : '0;

  // Next-state and datapath update for the fill sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    word_d  = word_q;
    if (bus.clear_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!hit_c) begin
            miss_d  = bus.inst_addr_i[ADDR_W-1:2];
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_gnt_i) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          word_d = put_byte(word_q, cnt_q, bus.mem_din_i);
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            state_d = S_REQ;
          end
        end
        S_WRITE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and fill registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (in_rst_c) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      miss_q  <= '0;
      word_q  <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      word_q  <= word_d;
    end
  end

endmodule
